// File: rtl/conv_4_ctrl.sv
// Sequencer for a 4x4 fp16 convolution engine: kernel fetch, column-strip image streaming, result tagging.
// Optional perf_cycles output is enabled by defining CONV4_CTRL_PERF_EN.
module conv_4_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 4,
    parameter int DIM_W       = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DIM_W-1:0]                  img_w,
    input  logic [DIM_W-1:0]                  img_h,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              kern_rd_en,
    output logic [1:0]                        kern_row,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] kern_rd_data,
    output logic                              img_rd_en,
    output logic [DIM_W-1:0]                  img_row,
    output logic [DIM_W-1:0]                  img_col,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] img_rd_data,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] conv_data,
    output logic                              conv_kernel_load,
    output logic                              conv_valid_in,
    output logic                              conv_valid_out,
    output logic                              res_valid,
    output logic [DIM_W-1:0]                  res_row,
    output logic [DIM_W-1:0]                  res_col
`ifdef CONV4_CTRL_PERF_EN
    ,
    output logic [31:0]                       perf_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_KLOAD, S_STREAM, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [DIM_W-1:0] r_w, r_h, r_row, r_col;
    logic [1:0]       r_kcnt, r_dcnt;
    logic             r_done, r_err;
    logic             r_beat_valid, r_beat_kern, r_beat_flush;
    logic [DIM_W-1:0] r_beat_k, r_beat_col;
    logic             r_vo;
    logic [DIM_W-1:0] r_vo_row, r_vo_col;
    logic             r_res_valid;
    logic [DIM_W-1:0] r_res_row, r_res_col;

    logic w_dims_ok, w_strip_end, w_last_slot, w_img_rd, w_reject;

    assign w_dims_ok   = (img_w >= DIM_W'(4)) && (img_h >= DIM_W'(4));
    assign w_reject    = (r_state == S_IDLE) && start && !w_dims_ok;
    // Slot r_row == r_h is the flush slot closing each strip.
    assign w_strip_end = (r_row == r_h);
    assign w_last_slot = w_strip_end && (r_col == (r_w - DIM_W'(4)));
    assign w_img_rd    = (r_state == S_STREAM) && !w_strip_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start && w_dims_ok) w_state_next = S_KLOAD;
            S_KLOAD:  if (r_kcnt == 2'd3)     w_state_next = S_STREAM;
            S_STREAM: if (w_last_slot)        w_state_next = S_DRAIN;
            S_DRAIN:  if (r_dcnt == 2'd3)     w_state_next = S_IDLE;
            default:                          w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w          <= '0;
            r_h          <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_kcnt       <= '0;
            r_dcnt       <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_beat_valid <= 1'b0;
            r_beat_kern  <= 1'b0;
            r_beat_flush <= 1'b0;
            r_beat_k     <= '0;
            r_beat_col   <= '0;
            r_vo         <= 1'b0;
            r_vo_row     <= '0;
            r_vo_col     <= '0;
            r_res_valid  <= 1'b0;
            r_res_row    <= '0;
            r_res_col    <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_w <= img_w;
                r_h <= img_h;
            end
            r_kcnt <= (r_state == S_KLOAD) ? r_kcnt + 2'd1 : 2'd0;
            r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 2'd1 : 2'd0;
            if (r_state == S_STREAM) begin
                if (w_strip_end) begin
                    r_row <= '0;
                    r_col <= w_last_slot ? '0 : r_col + DIM_W'(1);
                end else begin
                    r_row <= r_row + DIM_W'(1);
                end
            end
            r_done <= w_reject || (r_state == S_DRAIN && r_dcnt == 2'd3);
            r_err  <= w_reject;

            // Beat stage: tag travels one cycle behind its issue slot, alongside the read data.
            r_beat_valid <= (r_state == S_KLOAD) || (r_state == S_STREAM);
            r_beat_kern  <= (r_state == S_KLOAD);
            r_beat_flush <= (r_state == S_STREAM) && w_strip_end;
            r_beat_k     <= r_row;
            r_beat_col   <= r_col;

            // The engine completes a window once four rows have been shifted in.
            r_vo     <= r_beat_valid && !r_beat_kern && (r_beat_k >= DIM_W'(4));
            r_vo_row <= r_beat_k - DIM_W'(4);
            r_vo_col <= r_beat_col;

            r_res_valid <= r_vo;
            if (r_vo) begin
                r_res_row <= r_vo_row;
                r_res_col <= r_vo_col;
            end
        end
    end

    always_comb begin
        conv_data = '0;
        if (r_beat_valid && !r_beat_flush)
            conv_data = r_beat_kern ? kern_rd_data : img_rd_data;
    end

    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign err              = r_err;
    assign kern_rd_en       = (r_state == S_KLOAD);
    assign kern_row         = r_kcnt;
    assign img_rd_en        = w_img_rd;
    assign img_row          = w_img_rd ? r_row : '0;
    assign img_col          = w_img_rd ? r_col : '0;
    assign conv_valid_in    = r_beat_valid;
    assign conv_kernel_load = r_beat_valid && r_beat_kern;
    assign conv_valid_out   = r_vo;
    assign res_valid        = r_res_valid;
    assign res_row          = r_res_row;
    assign res_col          = r_res_col;

`ifdef CONV4_CTRL_PERF_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_perf <= '0;
        else if (r_state == S_IDLE && start) r_perf <= '0;
        else if (busy)                     r_perf <= r_perf + 32'd1;
    end
    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_conv_4_ctrl.sv
// Directed self-checking bench for conv_4_ctrl: job sequencing, beat data, result tagging, reset and error paths.
module tb_conv_4_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  img_w = '0, img_h = '0;
    logic        busy, done, err, kern_rd_en, img_rd_en;
    logic [1:0]  kern_row;
    logic [7:0]  img_row, img_col, res_row, res_col;
    logic [63:0] kern_rd_data = '0, img_rd_data = '0, conv_data;
    logic        conv_kernel_load, conv_valid_in, conv_valid_out, res_valid;
`ifdef CONV4_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    conv_4_ctrl #(.DATA_WIDTH(16), .KERNEL_SIZE(4), .DIM_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
        .busy(busy), .done(done), .err(err),
        .kern_rd_en(kern_rd_en), .kern_row(kern_row), .kern_rd_data(kern_rd_data),
        .img_rd_en(img_rd_en), .img_row(img_row), .img_col(img_col), .img_rd_data(img_rd_data),
        .conv_data(conv_data), .conv_kernel_load(conv_kernel_load),
        .conv_valid_in(conv_valid_in), .conv_valid_out(conv_valid_out),
        .res_valid(res_valid), .res_row(res_row), .res_col(res_col)
`ifdef CONV4_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt = 0;

    int kq_cyc[$], kq_row[$];
    int iq_cyc[$], iq_row[$], iq_col[$];
    int bq_cyc[$], bq_kl[$];
    logic [63:0] bq_data[$];
    int vq_cyc[$];
    int rq_cyc[$], rq_row[$], rq_col[$];
    int dq_cyc[$], dq_err[$];

    logic [106:0] all_out;
    assign all_out = {busy, done, err, kern_rd_en, kern_row, img_rd_en, img_row, img_col, conv_data,
                      conv_kernel_load, conv_valid_in, conv_valid_out, res_valid, res_row, res_col};

    function automatic logic [63:0] kpat(input int r);
        return 64'h1111_2222_3333_0000 + 64'(r);
    endfunction

    function automatic logic [63:0] ipat(input int r, input int c);
        return {32'h5A5A_0000 + 32'(r), 32'h00C3_0000 + 32'(c)};
    endfunction

    always @(posedge clk) cyc++;

    // Buffer model: one-cycle read latency, junk when not read so flush zeros are observable.
    always @(posedge clk) begin
        kern_rd_data <= kern_rd_en ? kpat(int'(kern_row)) : 64'hDEAD_BEEF_DEAD_BEEF;
        img_rd_data  <= img_rd_en ? ipat(int'(img_row), int'(img_col)) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (kern_rd_en)     begin kq_cyc.push_back(cyc); kq_row.push_back(int'(kern_row)); end
            if (img_rd_en)      begin iq_cyc.push_back(cyc); iq_row.push_back(int'(img_row)); iq_col.push_back(int'(img_col)); end
            if (conv_valid_in)  begin bq_cyc.push_back(cyc); bq_kl.push_back(int'(conv_kernel_load)); bq_data.push_back(conv_data); end
            if (conv_valid_out) vq_cyc.push_back(cyc);
            if (res_valid)      begin rq_cyc.push_back(cyc); rq_row.push_back(int'(res_row)); rq_col.push_back(int'(res_col)); end
            if (done)           begin dq_cyc.push_back(cyc); dq_err.push_back(int'(err)); end
            if (busy)           busy_cnt++;
        end
    end

    task automatic clear_logs();
        kq_cyc.delete(); kq_row.delete();
        iq_cyc.delete(); iq_row.delete(); iq_col.delete();
        bq_cyc.delete(); bq_kl.delete(); bq_data.delete();
        vq_cyc.delete();
        rq_cyc.delete(); rq_row.delete(); rq_col.delete();
        dq_cyc.delete(); dq_err.delete();
        busy_cnt = 0;
    endtask

    task automatic start_job(input int w, input int h, output int s);
        @(posedge clk); #1;
        img_w = 8'(w); img_h = 8'(h); start = 1'b1; s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == budget) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_img_rd(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (img_rd_en) break;
        end
        if (k == budget) begin
            n_tests++; n_fail++;
            $display("FAIL %s_imgwait: img_rd_en not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h, want 0", all_out);
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_4x4();
        int s, t0;
        clear_logs();
        start_job(4, 4, s);
        t0 = s + 5;
        wait_done("4x4", 100);
        n_tests++;
        if (kq_cyc.size() != 4) begin
            n_fail++; $display("FAIL 4x4_kern_count: got %0d, want 4", kq_cyc.size());
        end else for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (kq_row[i] != i || kq_cyc[i] != s + 1 + i) begin
                n_fail++; $display("FAIL 4x4_kern_%0d: row %0d cyc %0d, want row %0d cyc %0d", i, kq_row[i], kq_cyc[i], i, s + 1 + i);
            end
        end
        n_tests++;
        if (iq_cyc.size() != 4) begin
            n_fail++; $display("FAIL 4x4_img_count: got %0d, want 4", iq_cyc.size());
        end else for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (iq_row[i] != i || iq_col[i] != 0 || iq_cyc[i] != t0 + i) begin
                n_fail++; $display("FAIL 4x4_img_%0d: (%0d,%0d) cyc %0d, want (%0d,0) cyc %0d", i, iq_row[i], iq_col[i], iq_cyc[i], i, t0 + i);
            end
        end
        n_tests++;
        if (bq_cyc.size() != 9) begin
            n_fail++; $display("FAIL 4x4_beat_count: got %0d, want 9", bq_cyc.size());
        end else for (int i = 0; i < 9; i++) begin
            logic [63:0] ed;
            int ek;
            ed = (i < 4) ? kpat(i) : (i < 8) ? ipat(i - 4, 0) : 64'h0;
            ek = (i < 4) ? 1 : 0;
            n_tests++;
            if (bq_data[i] !== ed || bq_kl[i] != ek || bq_cyc[i] != s + 2 + i) begin
                n_fail++; $display("FAIL 4x4_beat_%0d: data %h kl %0d cyc %0d, want data %h kl %0d cyc %0d",
                                   i, bq_data[i], bq_kl[i], bq_cyc[i], ed, ek, s + 2 + i);
            end
        end
        n_tests++;
        if (vq_cyc.size() != 1 || vq_cyc[0] != t0 + 6) begin
            n_fail++; $display("FAIL 4x4_valid_out: count %0d first cyc %0d, want 1 at %0d", vq_cyc.size(), (vq_cyc.size() > 0) ? vq_cyc[0] : -1, t0 + 6);
        end
        n_tests++;
        if (rq_cyc.size() != 1 || rq_cyc[0] != t0 + 7 || rq_row[0] != 0 || rq_col[0] != 0) begin
            n_fail++; $display("FAIL 4x4_res: count %0d cyc %0d, want 1 at %0d with (0,0)", rq_cyc.size(), (rq_cyc.size() > 0) ? rq_cyc[0] : -1, t0 + 7);
        end
        n_tests++;
        if (dq_cyc.size() != 1 || dq_cyc[0] != t0 + 9 || dq_err[0] != 0) begin
            n_fail++; $display("FAIL 4x4_done: count %0d cyc %0d, want 1 at %0d err 0", dq_cyc.size(), (dq_cyc.size() > 0) ? dq_cyc[0] : -1, t0 + 9);
        end
        n_tests++;
        if (busy_cnt != 13 || busy !== 1'b0) begin
            n_fail++; $display("FAIL 4x4_busy: %0d busy cycles busy_now=%b, want 13 and 0", busy_cnt, busy);
        end
`ifdef CONV4_CTRL_PERF_EN
        n_tests++;
        if (perf_cycles !== 32'd13) begin
            n_fail++; $display("FAIL perf_after_done: got %0d, want 13", perf_cycles);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (perf_cycles !== 32'd13) begin
            n_fail++; $display("FAIL perf_held: got %0d, want 13", perf_cycles);
        end
`endif
    endtask

    task automatic test_6x5();
        int s, t0, ec;
        clear_logs();
        start_job(6, 5, s);
        t0 = s + 5;
        wait_done("6x5", 200);
        n_tests++;
        if (iq_cyc.size() != 15 || iq_cyc[14] != t0 + 16 || iq_row[14] != 4 || iq_col[14] != 2) begin
            n_fail++; $display("FAIL 6x5_img: count %0d, want 15 ending (4,2) at %0d", iq_cyc.size(), t0 + 16);
        end
        n_tests++;
        if (vq_cyc.size() != 6 || rq_cyc.size() != 6) begin
            n_fail++; $display("FAIL 6x5_counts: valid_out %0d res %0d, want 6 6", vq_cyc.size(), rq_cyc.size());
        end else for (int i = 0; i < 6; i++) begin
            ec = t0 + 6 * (i / 2) + 7 + (i % 2);
            n_tests++;
            if (rq_row[i] != i % 2 || rq_col[i] != i / 2 || rq_cyc[i] != ec || vq_cyc[i] + 1 != rq_cyc[i]) begin
                n_fail++; $display("FAIL 6x5_res_%0d: (%0d,%0d) cyc %0d vo %0d, want (%0d,%0d) cyc %0d vo %0d",
                                   i, rq_row[i], rq_col[i], rq_cyc[i], vq_cyc[i], i % 2, i / 2, ec, ec - 1);
            end
        end
        n_tests++;
        if (dq_cyc.size() != 1 || dq_cyc[0] != t0 + 22) begin
            n_fail++; $display("FAIL 6x5_done: count %0d cyc %0d, want 1 at %0d", dq_cyc.size(), (dq_cyc.size() > 0) ? dq_cyc[0] : -1, t0 + 22);
        end
    endtask

    task automatic test_err();
        int tw[2] = '{3, 8};
        int th[2] = '{8, 3};
        int s;
        for (int j = 0; j < 2; j++) begin
            clear_logs();
            start_job(tw[j], th[j], s);
            repeat (10) @(negedge clk);
            n_tests++;
            if (dq_cyc.size() != 1 || dq_cyc[0] != s + 1 || dq_err[0] != 1) begin
                n_fail++; $display("FAIL err_%0dx%0d_done: count %0d cyc %0d, want 1 at %0d with err", tw[j], th[j],
                                   dq_cyc.size(), (dq_cyc.size() > 0) ? dq_cyc[0] : -1, s + 1);
            end
            n_tests++;
            if (kq_cyc.size() != 0 || iq_cyc.size() != 0 || busy_cnt != 0) begin
                n_fail++; $display("FAIL err_%0dx%0d_activity: kern %0d img %0d busy %0d, want 0 0 0", tw[j], th[j],
                                   kq_cyc.size(), iq_cyc.size(), busy_cnt);
            end
        end
    endtask

    task automatic test_start_ignored();
        int s;
        clear_logs();
        start_job(5, 5, s);
        wait_img_rd("restart", 20);
        @(posedge clk); #1;
        img_w = 8'd4; img_h = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart", 200);
        repeat (20) @(negedge clk);
        n_tests++;
        if (rq_cyc.size() != 4) begin
            n_fail++; $display("FAIL restart_res_count: got %0d, want 4", rq_cyc.size());
        end else for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rq_row[i] != i % 2 || rq_col[i] != i / 2) begin
                n_fail++; $display("FAIL restart_res_%0d: (%0d,%0d), want (%0d,%0d)", i, rq_row[i], rq_col[i], i % 2, i / 2);
            end
        end
        n_tests++;
        if (dq_cyc.size() != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL restart_done: count %0d busy %b, want 1 and 0", dq_cyc.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        clear_logs();
        start_job(6, 5, s);
        wait_img_rd("rstmid", 20);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %h, want 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        clear_logs();
        repeat (30) @(negedge clk);
        n_tests++;
        if (dq_cyc.size() != 0 || busy_cnt != 0 || rq_cyc.size() != 0) begin
            n_fail++; $display("FAIL rstmid_quiet: done %0d busy %0d res %0d, want 0 0 0", dq_cyc.size(), busy_cnt, rq_cyc.size());
        end
        clear_logs();
        start_job(4, 4, s);
        wait_done("rstmid_4x4", 100);
        n_tests++;
        if (rq_cyc.size() != 1 || rq_cyc[0] != s + 12 || dq_cyc.size() != 1 || dq_cyc[0] != s + 14) begin
            n_fail++; $display("FAIL rstmid_rerun: res %0d done %0d, want res at %0d done at %0d", rq_cyc.size(), dq_cyc.size(), s + 12, s + 14);
        end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_6x5();
        test_err();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
